// File: rtl/fir_pkg.sv
// Shared constants, state encoding and default coefficients for the serial-MAC FIR.
package fir_pkg;
   localparam int NTAPS = 8;
   localparam int DW    = 3;
   localparam int CW    = 8;
   localparam int TW    = $clog2(NTAPS);
   localparam int PW    = DW + CW + 1;
   localparam int ACC_W = DW + CW + 1 + TW;

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   // Symmetric low-pass taps, sum 72
   localparam logic signed [CW-1:0] COEF_0 = 8'sd1;
   localparam logic signed [CW-1:0] COEF_1 = 8'sd4;
   localparam logic signed [CW-1:0] COEF_2 = 8'sd12;
   localparam logic signed [CW-1:0] COEF_3 = 8'sd19;
   localparam logic signed [CW-1:0] COEF_4 = 8'sd19;
   localparam logic signed [CW-1:0] COEF_5 = 8'sd12;
   localparam logic signed [CW-1:0] COEF_6 = 8'sd4;
   localparam logic signed [CW-1:0] COEF_7 = 8'sd1;
endpackage

// File: rtl/fir_coef_rom.sv
// Combinational tap-index to coefficient lookup.
module fir_coef_rom
   import fir_pkg::*;
(
   input  logic        [TW-1:0] tap_idx,
   output logic signed [CW-1:0] coef
);
   always_comb begin
      coef = '0;
      case (tap_idx)
         TW'(0):  coef = COEF_0;
         TW'(1):  coef = COEF_1;
         TW'(2):  coef = COEF_2;
         TW'(3):  coef = COEF_3;
         TW'(4):  coef = COEF_4;
         TW'(5):  coef = COEF_5;
         TW'(6):  coef = COEF_6;
         TW'(7):  coef = COEF_7;
         default: coef = '0;
      endcase
   end
endmodule

// File: rtl/fir_serial_mac.sv
// FIR filter with one time-shared multiply-accumulate; one output per accepted sample,
// NTAPS+2 cycles per sample.
module fir_serial_mac
   import fir_pkg::*;
(
   input  logic                    CLOCK_50,
   input  logic                    reset,
   input  logic        [DW-1:0]    sample_in,
   input  logic                    sample_valid,
   output logic                    sample_ready,
   output logic signed [ACC_W-1:0] filt_out,
   output logic                    filt_valid,
   output logic                    busy,
   output logic                    overrun
);
   state_t                  state, state_n;
   logic        [DW-1:0]    x [NTAPS];
   logic signed [ACC_W-1:0] acc;
   logic        [TW-1:0]    tap_idx;
   logic signed [CW-1:0]    coef;
   logic signed [DW:0]      xs;
   logic signed [PW-1:0]    prod;
   logic                    accept, mac_en, done_en;

   fir_coef_rom u_rom (.tap_idx(tap_idx), .coef(coef));

   assign accept = (state == IDLE) && sample_valid && sample_ready;
   // Sample is unsigned: zero-extend before the signed multiply
   assign xs     = $signed({1'b0, x[tap_idx]});
   assign prod   = PW'(xs) * PW'(coef);

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = MAC;
         MAC:     if (tap_idx == TW'(NTAPS-1)) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state != IDLE);
      mac_en  = (state == MAC);
      done_en = (state == DONE);
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NTAPS; k++) x[k] <= '0;
      end else if (accept) begin
         x[0] <= sample_in;
         for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         acc          <= '0;
         tap_idx      <= '0;
         filt_out     <= '0;
         filt_valid   <= 1'b0;
         sample_ready <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         // Ready whenever the next cycle is IDLE: covers post-reset, DONE and accept
         sample_ready <= (state_n == IDLE);
         filt_valid   <= done_en;
         if (accept) begin
            acc     <= '0;
            tap_idx <= '0;
         end else if (mac_en) begin
            acc     <= acc + ACC_W'(prod);
            tap_idx <= tap_idx + TW'(1);
         end
         if (done_en) filt_out <= acc;
         if (sample_valid && !sample_ready) overrun <= 1'b1;
      end
   end
endmodule

// File: tb/tb_fir_serial_mac.sv
// Scoreboarded directed test of fir_serial_mac: driver queues hand-computed results,
// negedge monitor checks timing, strobe, busy, overrun and values.
module tb_fir_serial_mac;
   import fir_pkg::*;

   logic                    CLOCK_50 = 1'b0;
   logic                    reset = 1'b1;
   logic        [DW-1:0]    sample_in = '0;
   logic                    sample_valid = 1'b0;
   logic                    sample_ready;
   logic signed [ACC_W-1:0] filt_out;
   logic                    filt_valid;
   logic                    busy;
   logic                    overrun;

   fir_serial_mac dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .sample_in(sample_in),
      .sample_valid(sample_valid), .sample_ready(sample_ready),
      .filt_out(filt_out), .filt_valid(filt_valid), .busy(busy), .overrun(overrun)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int nvec = 0, nerr = 0, cyc = 0, last_acc = -1;
   int exp_q[$];
   int acc_t[$];
   bit ov_exp = 1'b0, cont = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string nm);
      nvec++;
      nerr++;
      $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
   endtask

   // Accept stamps and sticky-overrun expectation, from the handshake inputs only
   always @(posedge CLOCK_50) begin
      cyc++;
      if (!reset) begin
         if (sample_valid && !sample_ready) ov_exp = 1'b1;
         if (sample_valid && sample_ready) begin
            if (cont && last_acc >= 0) chk("accept_interval", cyc - last_acc, NTAPS + 2);
            last_acc = cyc;
            acc_t.push_back(cyc);
         end
      end
   end

   // Monitor: result due NTAPS+1 edges after accept; busy for the edges in between
   always @(negedge CLOCK_50) begin
      bit due;
      int e;
      if (!reset) begin
         due = (acc_t.size() > 0) && (cyc - acc_t[0] == NTAPS + 1);
         chk("busy", int'(busy), int'((acc_t.size() > 0) && (cyc - acc_t[0] <= NTAPS)));
         chk("filt_valid", int'(filt_valid), int'(due));
         chk("overrun", int'(overrun), int'(ov_exp));
         if (due) begin
            void'(acc_t.pop_front());
            if (exp_q.size() == 0) fail_now("scoreboard_empty");
            else begin
               e = exp_q.pop_front();
               chk("filt_out", int'(filt_out), e);
            end
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      acc_t.delete();
      ov_exp = 1'b0;
      last_acc = -1;
      repeat (2) begin
         @(negedge CLOCK_50);
         sample_in    = DW'($urandom);
         sample_valid = 1'($urandom);
         chk("rst_ready", int'(sample_ready), 0);
         chk("rst_filt_valid", int'(filt_valid), 0);
         chk("rst_filt_out", int'(filt_out), 0);
         chk("rst_busy", int'(busy), 0);
         chk("rst_overrun", int'(overrun), 0);
      end
      sample_valid = 1'b0;
      @(posedge CLOCK_50);
      #5 reset = 1'b0;
      @(negedge CLOCK_50);
      chk("ready_before_edge", int'(sample_ready), 0);
      @(negedge CLOCK_50);
      chk("ready_after_edge", int'(sample_ready), 1);
   endtask

   task automatic send(input int v, input int e);
      int n = 0;
      @(negedge CLOCK_50);
      while (!sample_ready && n < 50) begin
         @(negedge CLOCK_50);
         n++;
      end
      if (!sample_ready) begin
         fail_now("ready_timeout");
         return;
      end
      sample_in    = DW'(v);
      sample_valid = 1'b1;
      exp_q.push_back(e);
      @(negedge CLOCK_50);
      sample_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((acc_t.size() > 0 || exp_q.size() > 0) && n < 200) begin
         @(negedge CLOCK_50);
         n++;
      end
      if (acc_t.size() > 0 || exp_q.size() > 0) fail_now("drain");
      repeat (2) @(negedge CLOCK_50);
   endtask

   task automatic impulse();
      int resp[9] = '{1, 4, 12, 19, 19, 12, 4, 1, 0};
      for (int i = 0; i < 9; i++) send((i == 0) ? 1 : 0, resp[i]);
      drain();
   endtask

   initial begin
      int dc[9]   = '{7, 35, 119, 252, 385, 469, 497, 504, 504};
      int ramp[8] = '{0, 1, 6, 23, 59, 114, 181, 252};
      int n;

      do_reset();
      impulse();

      for (int i = 0; i < 9; i++) send(7, dc[i]);
      drain();

      // Continuous offer: valid never drops, ramp advances on each accept
      @(posedge CLOCK_50);
      #5 do_reset();
      cont = 1'b1;
      sample_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         sample_in = DW'(k);
         n = 0;
         while (!sample_ready && n < 30) begin
            @(negedge CLOCK_50);
            n++;
         end
         if (!sample_ready) fail_now("cont_ready_timeout");
         else exp_q.push_back(ramp[k]);
         @(negedge CLOCK_50);
      end
      sample_valid = 1'b0;
      drain();
      cont = 1'b0;

      // Reset in the middle of MAC: interrupted result must never appear
      @(posedge CLOCK_50);
      #5 do_reset();
      send(5, 5);
      repeat (4) @(posedge CLOCK_50);
      #5 do_reset();
      impulse();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/fir_serial_mac.md
Name: fir_serial_mac

Overview:
- Consumer end of the 3-bit sample stream produced by the signal generator.
- Accepts unsigned 3-bit samples through a valid/ready handshake and keeps an NTAPS-deep delay line.
- Computes one FIR output per accepted sample using a single time-shared multiply-accumulate (one tap per clock).
- Feeds the filtered result and a one-cycle valid strobe to downstream display/capture logic.

Parameters:
- NTAPS, 8, number of filter taps / delay-line depth.
- DW, 3, input sample width (unsigned).
- CW, 8, coefficient width (signed two's complement).
- ACC_W, DW+CW+1+clog2(NTAPS) = 15, accumulator and output width (signed).

Ports:
- CLOCK_50  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- sample_in  in  DW  unsigned input sample.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  block can accept a sample this cycle (registered).
- filt_out  out  ACC_W  signed filter result; held between updates.
- filt_valid  out  1  one-cycle strobe: filt_out updated this cycle.
- busy  out  1  high while in MAC or DONE.
- overrun  out  1  sticky: a sample was offered while not ready.

Behaviour:
- Clock and reset (fixed): single clock CLOCK_50; reset is asynchronous and active-high.
- Reset values: state IDLE; delay line all 0; acc 0; tap_idx 0; filt_out 0; filt_valid 0; sample_ready 0; busy 0; overrun 0.
- sample_ready rises on the first CLOCK_50 edge after reset deasserts.
- Handshake: a sample is accepted on a rising edge where sample_valid and sample_ready are both 1. There is no backpressure upstream; offered samples not accepted are dropped.
- State IDLE:
  - sample_ready = 1.
  - On accept: x[0] <= sample_in; x[k] <= x[k-1] for k = 1..NTAPS-1 (x[NTAPS-1] is discarded); acc <= 0; tap_idx <= 0; sample_ready <= 0; go to MAC.
- State MAC (NTAPS cycles):
  - Each cycle: acc <= acc + signed({1'b0, x[tap_idx]}) * coef[tap_idx]; tap_idx++.
  - Go to DONE after the tap_idx == NTAPS-1 accumulation.
- State DONE (1 cycle):
  - filt_out <= acc; filt_valid <= 1; sample_ready <= 1; go to IDLE.
  - filt_valid is high for exactly one cycle.
- Latency: accept at edge E0 -> filt_valid and the new filt_out visible after edge E0+NTAPS+1 (E0+9 by default).
- Throughput: one sample per NTAPS+2 cycles. A continuous generator stream is effectively decimated by 10.
- Arithmetic:
  - Sample zero-extended to DW+1 signed bits.
  - Product width DW+CW+1, sign-extended into ACC_W.
  - No saturation needed: ACC_W covers the worst case by construction.
- Overrun: sets on any edge where sample_valid=1 and sample_ready=0. It stays set until reset. The sample is ignored and the delay line is not disturbed.
- Simultaneous DONE and sample_valid: sample_ready is still 0 in DONE, so the offer counts as an overrun. The sample is accepted only from the following IDLE cycle.
- Reset mid-operation:
  - Any state returns to IDLE immediately and asynchronously; all registers take their reset values.
  - No filt_valid is produced for the interrupted computation.
- Default coefficients (signed, tap 0..7): 1, 4, 12, 19, 19, 12, 4, 1 (sum 72).

Decomposition:
- Package fir_pkg holds:
  - NTAPS, DW, CW, ACC_W constants.
  - State enum {IDLE, MAC, DONE}.
  - Default coefficient constants.
- Sub-module fir_coef_rom: combinational case table mapping tap_idx (clog2(NTAPS) bits) to a CW-bit signed coefficient; default 0.
- Delay line, FSM and accumulator stay in fir_serial_mac.

Test Plan:
- Impulse: accept 1, then 0s on each ready -> successive filt_out = 1, 4, 12, 19, 19, 12, 4, 1, then 0.
- DC max: accept 7 repeatedly -> filt_out = 7, 35, 119, 252, 385, 469, 497, 504, then steady 504.
- Latency/strobe: single accept at edge E0 -> filt_valid high only in the cycle after E0+9; busy high for cycles E0+1..E0+9.
- Continuous offer: sample_valid held at 1 with the 0..7 ramp -> accepts exactly every 10 cycles; overrun = 1 one cycle after the first accept and stays 1.
- Reset mid-MAC: assert reset at MAC cycle 4 -> no filt_valid; filt_out = 0; sample_ready = 0. After release, an impulse reproduces the clean 1, 4, 12, ... sequence with no residue.
- Reset values: assert reset with random inputs -> all outputs 0 during reset; sample_ready = 1 one edge after deassertion.
